// File: rtl/fitness_wb_collector.sv
// Fitness write-back collector: stores scored energies per index and tracks the best individual.
// Define FITNESS_STATS_EN to add sum_energy_o, the running total of accepted energies.
module fitness_wb_collector #(
    parameter int SELF_FIT_LENGTH   = 10,
    parameter int INDIVIDUAL_LENGTH = 22,
    parameter int POP_SIZE          = 50,
    parameter int IDX_WIDTH         = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic                         wr_valid_i,
    input  logic [SELF_FIT_LENGTH-1:0]   total_energy_i,
    input  logic [INDIVIDUAL_LENGTH-1:0] individual_vec_i,
    input  logic [IDX_WIDTH-1:0]         ind_idx_i,
    input  logic [IDX_WIDTH-1:0]         rd_idx_i,
    output logic [SELF_FIT_LENGTH-1:0]   rd_fitness_o,
    output logic                         rd_valid_o,
    output logic [SELF_FIT_LENGTH-1:0]   best_energy_o,
    output logic [IDX_WIDTH-1:0]         best_idx_o,
    output logic [INDIVIDUAL_LENGTH-1:0] best_individual_o,
    output logic [IDX_WIDTH-1:0]         count_o,
    output logic                         busy_o,
    output logic                         gen_done_o,
    output logic                         dup_err_o,
    output logic                         range_err_o
`ifdef FITNESS_STATS_EN
    ,
    output logic [SELF_FIT_LENGTH+IDX_WIDTH-1:0] sum_energy_o
`endif
);

    localparam int ADDR_W = (POP_SIZE > 1) ? $clog2(POP_SIZE) : 1;
    // One extra bit so POP_SIZE == 2**IDX_WIDTH still compares correctly.
    localparam logic [IDX_WIDTH:0] POP_LIMIT = (IDX_WIDTH+1)'(POP_SIZE);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    logic [1:0]                   state_q, state_d;
    logic [POP_SIZE-1:0]          filled_q, filled_d;
    logic [IDX_WIDTH-1:0]         count_q, count_d;
    logic [SELF_FIT_LENGTH-1:0]   best_energy_q, best_energy_d;
    logic [IDX_WIDTH-1:0]         best_idx_q, best_idx_d;
    logic [INDIVIDUAL_LENGTH-1:0] best_ind_q, best_ind_d;
    logic [SELF_FIT_LENGTH-1:0]   rd_fitness_q, rd_fitness_d;
    logic                         rd_valid_q, rd_valid_d;
    logic                         gen_done_q, gen_done_d;
    logic                         dup_err_q, dup_err_d;
    logic                         range_err_q, range_err_d;
`ifdef FITNESS_STATS_EN
    logic [SELF_FIT_LENGTH+IDX_WIDTH-1:0] sum_q, sum_d;
`endif

    logic [SELF_FIT_LENGTH-1:0] fit_table_q [POP_SIZE];
    logic                       table_we;
    logic [ADDR_W-1:0]          wr_addr;
    logic [ADDR_W-1:0]          rd_addr;
    logic                       wr_in_range;
    logic                       rd_in_range;

    always_comb begin
        wr_in_range = ({1'b0, ind_idx_i} < POP_LIMIT);
        rd_in_range = ({1'b0, rd_idx_i} < POP_LIMIT);
        wr_addr     = ind_idx_i[ADDR_W-1:0];
        rd_addr     = rd_idx_i[ADDR_W-1:0];
    end

    // start_i wins over a same-cycle write; the write is simply lost.
    always_comb begin
        state_d       = state_q;
        filled_d      = filled_q;
        count_d       = count_q;
        best_energy_d = best_energy_q;
        best_idx_d    = best_idx_q;
        best_ind_d    = best_ind_q;
        dup_err_d     = dup_err_q;
        range_err_d   = range_err_q;
        gen_done_d    = 1'b0;
        table_we      = 1'b0;
`ifdef FITNESS_STATS_EN
        sum_d         = sum_q;
`endif
        if (start_i) begin
            state_d       = ST_COLLECT;
            filled_d      = '0;
            count_d       = '0;
            best_energy_d = '1;
            best_idx_d    = '0;
            best_ind_d    = '0;
            dup_err_d     = 1'b0;
            range_err_d   = 1'b0;
`ifdef FITNESS_STATS_EN
            sum_d         = '0;
`endif
        end else if (wr_valid_i) begin
            case (state_q)
                ST_COLLECT: begin
                    if (!wr_in_range) begin
                        range_err_d = 1'b1;
                    end else if (filled_q[wr_addr]) begin
                        dup_err_d = 1'b1;
                    end else begin
                        table_we          = 1'b1;
                        filled_d[wr_addr] = 1'b1;
                        count_d           = count_q + 1'b1;
`ifdef FITNESS_STATS_EN
                        sum_d             = sum_q + {{IDX_WIDTH{1'b0}}, total_energy_i};
`endif
                        // First arrival always loads so an all-ones energy can still become best.
                        if ((count_q == '0) || (total_energy_i < best_energy_q)) begin
                            best_energy_d = total_energy_i;
                            best_idx_d    = ind_idx_i;
                            best_ind_d    = individual_vec_i;
                        end
                        if (({1'b0, count_q} + 1'b1) == POP_LIMIT) begin
                            state_d    = ST_DONE;
                            gen_done_d = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    dup_err_d = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Read port samples the pre-edge table, so a same-edge write is not visible yet.
    always_comb begin
        rd_fitness_d = rd_in_range ? fit_table_q[rd_addr] : '0;
        rd_valid_d   = rd_in_range ? filled_q[rd_addr] : 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            filled_q      <= '0;
            count_q       <= '0;
            best_energy_q <= '1;
            best_idx_q    <= '0;
            best_ind_q    <= '0;
            rd_fitness_q  <= '0;
            rd_valid_q    <= 1'b0;
            gen_done_q    <= 1'b0;
            dup_err_q     <= 1'b0;
            range_err_q   <= 1'b0;
`ifdef FITNESS_STATS_EN
            sum_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            filled_q      <= filled_d;
            count_q       <= count_d;
            best_energy_q <= best_energy_d;
            best_idx_q    <= best_idx_d;
            best_ind_q    <= best_ind_d;
            rd_fitness_q  <= rd_fitness_d;
            rd_valid_q    <= rd_valid_d;
            gen_done_q    <= gen_done_d;
            dup_err_q     <= dup_err_d;
            range_err_q   <= range_err_d;
`ifdef FITNESS_STATS_EN
            sum_q         <= sum_d;
`endif
        end
    end

    // Table contents are meaningless until the matching filled bit is set, so no reset.
    always_ff @(posedge clk_i) begin
        if (table_we) begin
            fit_table_q[wr_addr] <= total_energy_i;
        end
    end

    assign rd_fitness_o      = rd_fitness_q;
    assign rd_valid_o        = rd_valid_q;
    assign best_energy_o     = best_energy_q;
    assign best_idx_o        = best_idx_q;
    assign best_individual_o = best_ind_q;
    assign count_o           = count_q;
    assign busy_o            = (state_q == ST_COLLECT);
    assign gen_done_o        = gen_done_q;
    assign dup_err_o         = dup_err_q;
    assign range_err_o       = range_err_q;
`ifdef FITNESS_STATS_EN
    assign sum_energy_o      = sum_q;
`endif

endmodule
